// File: rtl/memoria_dados.sv
// memoria_dados: MIPS data memory with byte/half/word access, fault detection and sticky error record
module memoria_dados #(
  parameter int PALAVRAS = 256,
  localparam int IDX_BITS = $clog2(PALAVRAS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Endereco,
  input  logic [31:0] DadoEscrita,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  Tamanho,
  input  logic        SemSinal,
  output logic [31:0] DadoLido,
  output logic        Falha,
  output logic        ErroSticky,
  output logic [31:0] EnderecoErro
);
  logic [31:0] mem [PALAVRAS];
  logic [IDX_BITS-1:0] idx;
  logic [4:0] sh;
  logic fora, desal;
  logic [31:0] palavra, desl, mascara, novo;
  // address decode, fault detection, lane extraction and store merge
  always_comb begin
    idx = Endereco[IDX_BITS+1:2];
    sh = {Endereco[1:0], 3'b000};
    fora = |Endereco[31:IDX_BITS+2];
    desal = (Tamanho == 2'b01 && Endereco[0]) || (Tamanho == 2'b10 && Endereco[1:0] != 2'b00);
    Falha = (MemRead | MemWrite) & (fora | desal | (Tamanho == 2'b11));
    palavra = mem[idx];
    desl = palavra >> sh;
    DadoLido = (!MemRead || Falha) ? 32'h0 :
               Tamanho == 2'b00 ? {{24{~SemSinal & desl[7]}}, desl[7:0]} :
               Tamanho == 2'b01 ? {{16{~SemSinal & desl[15]}}, desl[15:0]} : palavra;
    mascara = Tamanho == 2'b00 ? 32'h0000_00FF << sh :
              Tamanho == 2'b01 ? 32'h0000_FFFF << sh : 32'hFFFF_FFFF;
    novo = (palavra & ~mascara) | ((DadoEscrita << sh) & mascara);
  end
  // storage: cleared by reset, faulting stores suppressed
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int i = 0; i < PALAVRAS; i++) mem[i] <= 32'h0;
    else if (MemWrite && !Falha)
      mem[idx] <= novo;
  // first-fault record, held until reset
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ErroSticky <= 1'b0;
      EnderecoErro <= 32'h0;
    end else if (Falha && !ErroSticky) begin
      ErroSticky <= 1'b1;
      EnderecoErro <= Endereco;
    end
endmodule

// File: tb/tb_memoria_dados.sv
// tb_memoria_dados: table-driven scoreboard bench for memoria_dados
module tb_memoria_dados;
  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] Endereco = '0, DadoEscrita = '0;
  logic MemRead = 1'b0, MemWrite = 1'b0, SemSinal = 1'b0;
  logic [1:0] Tamanho = 2'b10;
  logic [31:0] DadoLido, EnderecoErro;
  logic Falha, ErroSticky;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] q [$];

  memoria_dados #(.PALAVRAS(256)) dut (
    .clk(clk), .reset(reset), .Endereco(Endereco), .DadoEscrita(DadoEscrita),
    .MemRead(MemRead), .MemWrite(MemWrite), .Tamanho(Tamanho), .SemSinal(SemSinal),
    .DadoLido(DadoLido), .Falha(Falha), .ErroSticky(ErroSticky), .EnderecoErro(EnderecoErro)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, d;
    logic r, w;
    logic [1:0] t;
    logic s;
    logic [31:0] ed;
    logic ef, es;
    logic [31:0] ea;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act);
    logic [31:0] e;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: got %h, scoreboard empty", nm, act);
    end else begin
      e = q.pop_front();
      if (act !== e) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", nm, act, e);
      end
    end
  endtask

  task automatic drive(input logic [31:0] a, d, input logic r, w, input logic [1:0] t, input logic s);
    Endereco = a; DadoEscrita = d; MemRead = r; MemWrite = w; Tamanho = t; SemSinal = s;
  endtask

  vec_t v [$];

  initial begin
    v = '{
      '{32'h000, 32'hDEADBEEF, 0, 1, 2'b10, 0, 32'h0,        0, 0, 32'h0},
      '{32'h000, 32'h0,        1, 0, 2'b10, 0, 32'hDEADBEEF, 0, 0, 32'h0},
      '{32'h001, 32'hFFFFFF7F, 0, 1, 2'b00, 0, 32'h0,        0, 0, 32'h0},
      '{32'h000, 32'h0,        1, 0, 2'b10, 0, 32'hDEAD7FEF, 0, 0, 32'h0},
      '{32'h003, 32'h0,        1, 0, 2'b00, 0, 32'hFFFFFFDE, 0, 0, 32'h0},
      '{32'h003, 32'h0,        1, 0, 2'b00, 1, 32'h000000DE, 0, 0, 32'h0},
      '{32'h002, 32'h0,        1, 0, 2'b01, 0, 32'hFFFFDEAD, 0, 0, 32'h0},
      '{32'h002, 32'h0,        1, 0, 2'b01, 1, 32'h0000DEAD, 0, 0, 32'h0},
      '{32'h001, 32'h0,        1, 0, 2'b00, 0, 32'h0000007F, 0, 0, 32'h0},
      '{32'h002, 32'h1234BEEF, 0, 1, 2'b01, 0, 32'h0,        0, 0, 32'h0},
      '{32'h000, 32'h0,        1, 0, 2'b10, 0, 32'hBEEF7FEF, 0, 0, 32'h0},
      '{32'h004, 32'h0BADF00D, 0, 1, 2'b10, 0, 32'h0,        0, 0, 32'h0},
      '{32'h010, 32'h11111111, 0, 1, 2'b10, 0, 32'h0,        0, 0, 32'h0},
      '{32'h010, 32'hAAAAAAAA, 1, 1, 2'b10, 0, 32'h11111111, 0, 0, 32'h0},
      '{32'h010, 32'h0,        1, 0, 2'b10, 0, 32'hAAAAAAAA, 0, 0, 32'h0},
      '{32'h012, 32'h0,        1, 0, 2'b01, 0, 32'hFFFFAAAA, 0, 0, 32'h0},
      '{32'h3FC, 32'hCAFEF00D, 0, 1, 2'b10, 0, 32'h0,        0, 0, 32'h0},
      '{32'h3FC, 32'h0,        1, 0, 2'b10, 0, 32'hCAFEF00D, 0, 0, 32'h0},
      '{32'h006, 32'h12345678, 0, 1, 2'b10, 0, 32'h0,        1, 0, 32'h0},
      '{32'h004, 32'h0,        1, 0, 2'b10, 0, 32'h0BADF00D, 0, 1, 32'h6},
      '{32'h401, 32'h0,        1, 0, 2'b10, 0, 32'h0,        1, 1, 32'h6},
      '{32'h400, 32'h000000EE, 0, 1, 2'b00, 0, 32'h0,        1, 1, 32'h6},
      '{32'h000, 32'h0,        1, 0, 2'b10, 0, 32'hBEEF7FEF, 0, 1, 32'h6},
      '{32'h000, 32'h0,        1, 0, 2'b11, 0, 32'h0,        1, 1, 32'h6},
      '{32'h000, 32'h0,        0, 0, 2'b11, 0, 32'h0,        0, 1, 32'h6},
      '{32'h001, 32'h0,        1, 0, 2'b01, 0, 32'h0,        1, 1, 32'h6},
      '{32'h010, 32'h0,        1, 0, 2'b10, 0, 32'hAAAAAAAA, 0, 1, 32'h6}
    };
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    q.push_back(32'h0); q.push_back(32'h0);
    #1;
    chk("reset sticky", {31'b0, ErroSticky});
    chk("reset eaddr", EnderecoErro);
    foreach (v[i]) begin
      @(negedge clk);
      drive(v[i].a, v[i].d, v[i].r, v[i].w, v[i].t, v[i].s);
      q.push_back(v[i].ed); q.push_back({31'b0, v[i].ef});
      q.push_back({31'b0, v[i].es}); q.push_back(v[i].ea);
      #1;
      chk($sformatf("vec%0d dado", i), DadoLido);
      chk($sformatf("vec%0d falha", i), {31'b0, Falha});
      chk($sformatf("vec%0d sticky", i), {31'b0, ErroSticky});
      chk($sformatf("vec%0d eaddr", i), EnderecoErro);
    end
    @(negedge clk);
    drive(32'h020, 32'hFFFFFFFF, 0, 1, 2'b10, 0);
    #1 reset = 1'b1;
    #1;
    q.push_back(32'h0); q.push_back(32'h0);
    chk("async sticky", {31'b0, ErroSticky});
    chk("async eaddr", EnderecoErro);
    drive(32'h000, 32'h0, 1, 0, 2'b10, 0);
    #1 q.push_back(32'h0);
    chk("async lw 0x00", DadoLido);
    drive(32'h010, 32'h0, 1, 0, 2'b10, 0);
    #1 q.push_back(32'h0);
    chk("async lw 0x10", DadoLido);
    drive(32'h020, 32'hFFFFFFFF, 1, 1, 2'b10, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(32'h020, 32'h0, 1, 0, 2'b10, 0);
    #1 q.push_back(32'h0);
    chk("post reset lw 0x20", DadoLido);
    @(negedge clk);
    drive(32'h3FC, 32'h0, 1, 0, 2'b10, 0);
    #1 q.push_back(32'h0); q.push_back(32'h0);
    chk("post reset lw 0x3FC", DadoLido);
    chk("post reset sticky", {31'b0, ErroSticky});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
